// File: rtl/ahb_wrr_arbiter.sv
// ahb_wrr_arbiter: weighted round-robin AHB arbiter with priority master, per-master quanta and lock support
module ahb_wrr_arbiter #(
  parameter int N_MASTERS = 5,
  parameter int WW = 8,
  parameter int MW = 4,
  parameter int PRIO_IDX = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [N_MASTERS-1:0]    HBUSREQ,
  input  logic [N_MASTERS-1:0]    HLOCK,
  input  logic                    HREADY,
  input  logic                    PRIO_EN,
  input  logic [N_MASTERS*WW-1:0] WEIGHTS,
  output logic [N_MASTERS-1:0]    HGRANT,
  output logic [MW-1:0]           HMASTER,
  output logic [MW-1:0]           HMASTER_D,
  output logic                    HMASTLOCK,
  output logic                    BUSY
);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state, state_n;
  logic [MW-1:0] ptr, ptr_n, owner_n, rr_sel, sel;
  logic [WW-1:0] cnt, cnt_n, wq, wq_n, w_raw, w_eff;
  logic [N_MASTERS-1:0] own_oh, grant_n;
  logic rr_found, prio_req, found, at_max, prio_own, trig, pick, lock_n;
  int c;
  always_comb begin
    rr_found = 1'b0;
    rr_sel = '0;
    c = 0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      c = (int'(ptr) + k) % N_MASTERS;
      if (|(HBUSREQ & (N_MASTERS'(1) << c)) && !(PRIO_EN && c == PRIO_IDX)) begin
        rr_found = 1'b1;
        rr_sel = MW'(c);
      end
    end
  end
  always_comb begin
    prio_req = PRIO_EN && HBUSREQ[PRIO_IDX];
    sel = prio_req ? MW'(PRIO_IDX) : rr_sel;
    found = prio_req || rr_found;
    w_raw = '0;
    for (int i = 0; i < N_MASTERS; i++)
      if (sel == MW'(i)) w_raw = WEIGHTS[i*WW +: WW];
    w_eff = (w_raw == '0) ? WW'(1) : w_raw;
  end
  // the priority master is exempt from quantum expiry while PRIO_EN is set
  always_comb begin
    own_oh = N_MASTERS'(1) << HMASTER;
    at_max = cnt == wq - WW'(1);
    prio_own = PRIO_EN && HMASTER == MW'(PRIO_IDX);
    trig = (at_max && !prio_own) || !(|(HBUSREQ & own_oh)) || (prio_req && !prio_own);
    pick = (state == IDLE) ? found : (HREADY && !(|(HLOCK & own_oh)) && trig);
    state_n = pick ? (found ? OWN : IDLE) : state;
    owner_n = (pick && found) ? sel : HMASTER;
    ptr_n = (pick && found && !prio_req) ? rr_sel : ptr;
    wq_n = (pick && found) ? w_eff : wq;
    cnt_n = (pick && found) ? '0 : (state == OWN && HREADY && !at_max) ? cnt + WW'(1) : cnt;
    grant_n = (state_n == OWN) ? N_MASTERS'(1) << owner_n : '0;
    lock_n = |(HLOCK & grant_n);
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      ptr <= MW'(N_MASTERS - 1);
      cnt <= '0;
      wq <= WW'(1);
      HGRANT <= '0;
      HMASTER <= '0;
      HMASTER_D <= '0;
      HMASTLOCK <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      wq <= wq_n;
      HGRANT <= grant_n;
      HMASTER <= owner_n;
      HMASTER_D <= HREADY ? HMASTER : HMASTER_D;
      HMASTLOCK <= lock_n;
      BUSY <= state_n == OWN;
    end
  end
  always_ff @(posedge CLK)
    if (!RESET) assert (!$isunknown(HBUSREQ)) else $error("HBUSREQ carries X/Z");
endmodule

// File: tb/tb_ahb_wrr_arbiter.sv
// tb_ahb_wrr_arbiter: directed and randomized checks of ahb_wrr_arbiter against a cycle-level reference model
module tb_ahb_wrr_arbiter;
  localparam int N = 5;
  localparam int P = 4;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [N-1:0] HBUSREQ = '0, HLOCK = '0;
  logic HREADY = 1'b1, PRIO_EN = 1'b0;
  logic [N*8-1:0] WEIGHTS = '0;
  logic [N-1:0] HGRANT;
  logic [3:0] HMASTER, HMASTER_D;
  logic HMASTLOCK, BUSY;
  int checks = 0, errors = 0;
  bit m_busy, m_lock;
  int m_owner, m_used, m_quota, m_ptr, m_mstd;
  int seq [8] = '{0, 0, 0, 1, 1, 2, 3, 4};

  ahb_wrr_arbiter #(.N_MASTERS(N), .WW(8), .MW(4), .PRIO_IDX(P)) dut (
    .CLK(CLK), .RESET(RESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HREADY(HREADY),
    .PRIO_EN(PRIO_EN), .WEIGHTS(WEIGHTS), .HGRANT(HGRANT), .HMASTER(HMASTER),
    .HMASTER_D(HMASTER_D), .HMASTLOCK(HMASTLOCK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_used = 0; m_quota = 1; m_ptr = N - 1; m_mstd = 0; m_lock = 0;
  endtask

  // one bus cycle of the arbitration rules, evaluated on the inputs held across the edge
  task automatic model_step();
    bit found, preq, hand;
    int sel, o, w;
    preq = PRIO_EN && HBUSREQ[P];
    found = 0;
    sel = 0;
    if (preq) begin
      found = 1;
      sel = P;
    end else
      for (int k = 1; k <= N; k++) begin
        int cand = (m_ptr + k) % N;
        if (!found && HBUSREQ[cand] && !(PRIO_EN && cand == P)) begin
          found = 1;
          sel = cand;
        end
      end
    o = m_owner;
    hand = !m_busy || (HREADY && !HLOCK[o] &&
           ((m_used == m_quota - 1 && !(PRIO_EN && o == P)) || !HBUSREQ[o] || (preq && o != P)));
    if (hand) begin
      if (found) begin
        m_busy = 1;
        m_owner = sel;
        m_used = 0;
        w = (WEIGHTS >> (sel * 8)) & 8'hFF;
        m_quota = (w == 0) ? 1 : w;
        if (!preq) m_ptr = sel;
      end else m_busy = 0;
    end else if (m_busy && HREADY && m_used < m_quota - 1) m_used++;
    if (HREADY) m_mstd = o;
    m_lock = m_busy && HLOCK[m_owner];
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
    chk("HGRANT", 32'(HGRANT), m_busy ? 32'(1) << m_owner : 32'd0);
    chk("HMASTER", 32'(HMASTER), 32'(m_owner));
    chk("HMASTER_D", 32'(HMASTER_D), 32'(m_mstd));
    chk("HMASTLOCK", 32'(HMASTLOCK), 32'(m_lock));
    chk("BUSY", 32'(BUSY), 32'(m_busy));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_HGRANT", 32'(HGRANT), 32'd0);
    chk("rst_BUSY", 32'(BUSY), 32'd0);
    RESET = 1'b0;
    repeat (3) step();
    chk("idle_BUSY", 32'(BUSY), 32'd0);
    WEIGHTS = {8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
    HBUSREQ = 5'b11111;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("rot_seq", 32'(HMASTER), 32'(seq[i % 8]));
      chk("rot_nogap", 32'(BUSY), 32'd1);
    end
    RESET = 1'b1;
    #1;
    chk("async_HGRANT", 32'(HGRANT), 32'd0);
    chk("async_HMASTER", 32'(HMASTER), 32'd0);
    chk("async_BUSY", 32'(BUSY), 32'd0);
    model_reset();
    @(posedge CLK);
    #1 RESET = 1'b0;
    WEIGHTS = {8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
    HBUSREQ = 5'b00001;
    repeat (2) step();
    HBUSREQ = 5'b00011;
    HREADY = 1'b0;
    repeat (4) begin
      step();
      chk("wait_frozen", 32'(HMASTER), 32'd0);
    end
    HREADY = 1'b1;
    repeat (3) step();
    PRIO_EN = 1'b1;
    HBUSREQ = 5'b01111;
    repeat (6) step();
    HBUSREQ = 5'b11111;
    repeat (3) step();
    chk("prio_owner", 32'(HMASTER), 32'(P));
    HBUSREQ = 5'b01111;
    repeat (4) step();
    HBUSREQ = 5'b00010;
    HLOCK = 5'b00010;
    WEIGHTS[15:8] = 8'd1;
    repeat (4) step();
    HBUSREQ = 5'b11111;
    repeat (4) step();
    chk("lock_hold", 32'(HMASTER), 32'd1);
    chk("lock_flag", 32'(HMASTLOCK), 32'd1);
    HLOCK = '0;
    repeat (2) step();
    chk("lock_to_prio", 32'(HMASTER), 32'(P));
    PRIO_EN = 1'b0;
    HBUSREQ = 5'b01000;
    repeat (6) step();
    HBUSREQ = '0;
    step();
    chk("drop_idle", 32'(HGRANT), 32'd0);
    chk("drop_hmaster", 32'(HMASTER), 32'd3);
    step();
    chk("drop_hmaster_d", 32'(HMASTER_D), 32'd3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) HBUSREQ = N'($urandom);
      HLOCK = HLOCK ^ (N'($urandom) & N'($urandom) & N'($urandom));
      HREADY = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 199) == 0) PRIO_EN = ~PRIO_EN;
      if ($urandom_range(0, 49) == 0)
        for (int m = 0; m < N; m++) WEIGHTS[m*8 +: 8] = 8'($urandom_range(0, 4));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
